char_rle: RTL and testbench



---
 rtl/char_stream_pkg.sv | 26 ++
 rtl/char_rle_run_fifo.sv | 88 ++++++++
 rtl/char_rle.sv | 129 ++++++++++++
 tb/tb_char_rle.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_stream_pkg.sv
// ---------------------------------------------------------------------------
// char_stream_pkg
//   Shared types for the character-stream path.
//   - DW_DEF / CW_DEF : default character width and run-count width
//   - run_t           : one encoded run {character, count, last-of-stream}
//   - rle_state_e     : run-length encoder states
// ---------------------------------------------------------------------------
package char_stream_pkg;

    localparam int DW_DEF = 8;
    localparam int CW_DEF = 4;

    // Field order matches the packed vector that flows through run_fifo.
    typedef struct packed {
        logic [DW_DEF-1:0] ch;
        logic [CW_DEF-1:0] cnt;
        logic              last;
    } run_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no open run
        RUN   = 2'd1,   // a run is open and may still grow
        FLUSH = 2'd2    // stream ended, final run waits for FIFO space
    } rle_state_e;

endpackage

// File: rtl/char_rle_run_fifo.sv
// ---------------------------------------------------------------------------
// run_fifo
//   Synchronous FIFO with a registered head entry.
//   Ports:
//     clk, rst      : clock, asynchronous active-low reset
//     push/push_data: write one entry (ignored when full)
//     pop           : drop the head entry (ignored when empty)
//     head_data     : current head entry, all zeros when empty
//     full/empty    : occupancy flags
//     count         : number of stored entries, 0..DEPTH
//   A pushed entry is visible at the head the cycle after the push.
// ---------------------------------------------------------------------------
module run_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        push_ok  = push && (count_q != FULL_CNT);
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
        // Next head: the entry being written this cycle bypasses the array
        // when it lands exactly in the slot that becomes the head.
        if (count_d == '0) begin
            head_d = '0;
        end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_data = head_q;
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/char_rle.sv
// ---------------------------------------------------------------------------
// char_rle
//   Run-length encoder for an 8-bit character stream. Each accepted
//   character extends the open run or closes it and opens a new one;
//   closed runs go through a small FIFO as (char, count, last) entries.
//   in_last closes the stream: the final run is pushed tagged as last.
//   Ports:
//     clk, rst                          : clock, async active-low reset
//     in_valid/in_ready/in_char/in_last : input character beat
//     out_valid/out_ready               : output handshake (FIFO head)
//     out_char/out_count/out_last       : head run entry
// ---------------------------------------------------------------------------
module char_rle
    import char_stream_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_char,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_char,
    output logic [CW-1:0] out_count,
    output logic          out_last
);

    localparam int            RW      = DW + CW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    rle_state_e    state_q, state_d;
    logic [DW-1:0] cur_char_q, cur_char_d;
    logic [CW-1:0] cur_cnt_q, cur_cnt_d;

    logic                   accept;
    logic                   push;
    logic [RW-1:0]          push_data;
    logic [RW-1:0]          head_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop;

    always_comb begin
        state_d    = state_q;
        cur_char_d = cur_char_q;
        cur_cnt_d  = cur_cnt_q;
        push       = 1'b0;
        push_data  = '0;
        in_ready   = !fifo_full && (state_q != FLUSH);
        accept     = in_valid && in_ready;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_char_d = in_char;
                    cur_cnt_d  = CNT_ONE;
                    state_d    = in_last ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if ((in_char == cur_char_q) && (cur_cnt_q != CNT_MAX)) begin
                        cur_cnt_d = cur_cnt_q + CNT_ONE;
                    end else begin
                        // Different character or saturated count: close the
                        // run. accept implies the FIFO has room for it.
                        push       = 1'b1;
                        push_data  = {cur_char_q, cur_cnt_q, 1'b0};
                        cur_char_d = in_char;
                        cur_cnt_d  = CNT_ONE;
                    end
                    if (in_last) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_data = {cur_char_q, cur_cnt_q, 1'b1};
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_char_q <= '0;
            cur_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_char_q <= cur_char_d;
            cur_cnt_q  <= cur_cnt_d;
        end
    end

    assign pop = out_ready && !fifo_empty;

    run_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_run_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid                       = (fifo_count != '0);
    assign {out_char, out_count, out_last} = head_data;

endmodule

// File: tb/tb_char_rle.sv
module tb_char_rle;

    localparam int MAXC = 15;

    typedef struct packed {
        logic [7:0] ch;
        logic [3:0] cnt;
        logic       last;
    } ent_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic [3:0] out_count;
    logic       out_last;

    char_rle #(.DW(8), .CW(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_count (out_count),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    ent_t exp_q[$];
    int   ready_mode = 0;     // 0: always ready, 1: never ready, 2: random
    bit   mon_en = 0;
    int   low_cnt = 0;
    bit   prev_stall = 0;
    ent_t prev_ent;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Reference: run-length encode a whole stream, splitting runs at MAXC,
    // final run tagged last. Returns a printable serialisation.
    function automatic string rle_model(input string s, input bit enqueue);
        string r = "";
        byte   cur;
        int    n = 0;
        ent_t  e;
        for (int i = 0; i < s.len(); i++) begin
            if (n > 0 && s[i] == cur && n < MAXC) begin
                n++;
            end else begin
                if (n > 0) begin
                    e = '{ch: cur, cnt: 4'(n), last: 1'b0};
                    if (enqueue) exp_q.push_back(e);
                    r = $sformatf("%s%c%0d", r, cur, n);
                end
                cur = s[i];
                n   = 1;
            end
        end
        if (n > 0) begin
            e = '{ch: cur, cnt: 4'(n), last: 1'b1};
            if (enqueue) exp_q.push_back(e);
            r = $sformatf("%s%c%0d*", r, cur, n);
        end
        return r;
    endfunction

    // Sink: out_ready changes on the falling edge.
    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Compare process: sampled mid low phase, away from the rising edge.
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (!in_ready) low_cnt++;
            if (prev_stall) begin
                chk("stall_stable", {out_valid, out_char, out_count, out_last},
                    {1'b1, prev_ent});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %c%0d last=%0d expected no entry",
                             out_char, out_count, out_last);
                end else begin
                    $display("pop  %c%0d last=%0d", out_char, out_count, out_last);
                    chk("out_entry", {out_char, out_count, out_last}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_ent   = {out_char, out_count, out_last};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Drives one character; called on a falling edge, returns on one.
    task automatic send_char(input byte c, input bit last);
        bit acc = 0;
        int waited = 0;
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        while (!acc && waited < 2000) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) chk("accept_within_bound", 32'(acc), 32'd1);
    endtask

    task automatic send_stream(input string s, input bit with_last, input bit add_exp,
                               input int maxgap);
        string dummy;
        if (add_exp) dummy = rle_model(s, 1'b1);
        for (int i = 0; i < s.len(); i++) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            send_char(s[i], with_last && (i == s.len() - 1));
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        string s;
        string m;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  {out_char, out_count, out_last}, 32'd0);
        chk("reset_in_ready",  32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Model pins against hand-worked encodings.
        m = rle_model("AABABA__JUSTMONIKA__CDEDE", 1'b0);
        checks++;
        if (m != "A2B1A1B1A1_2J1U1S1T1M1O1N1I1K1A1_2C1D1E1D1E1*") begin
            errors++;
            $display("FAIL model_pin1: got %s expected A2B1A1B1A1_2J1U1S1T1M1O1N1I1K1A1_2C1D1E1D1E1*", m);
        end
        m = rle_model("ZZZZZZZZZZZZZZZZZZZZ", 1'b0);
        checks++;
        if (m != "Z15Z5*") begin
            errors++;
            $display("FAIL model_pin2: got %s expected Z15Z5*", m);
        end
        m = rle_model("QQ", 1'b0);
        checks++;
        if (m != "Q2*") begin
            errors++;
            $display("FAIL model_pin3: got %s expected Q2*", m);
        end

        // Test 1: mixed stream, continuous input, sink always ready.
        ready_mode = 0;
        @(negedge clk);
        low_cnt = 0;
        send_stream("AABABA__JUSTMONIKA__CDEDE", 1'b1, 1'b1, 0);
        drain("t1");
        chk("t1_in_ready_low_cycles", 32'(low_cnt), 32'd1);

        // Test 2: saturation.
        send_stream("ZZZZZZZZZZZZZZZZZZZZ", 1'b1, 1'b1, 0);
        drain("t2");

        // Test 4: single character, then a clean follow-on stream.
        send_stream("X", 1'b1, 1'b1, 0);
        drain("t4a");
        send_stream("XY", 1'b1, 1'b1, 0);
        drain("t4b");

        // Test 5: two equal characters close in one entry.
        send_stream("QQ", 1'b1, 1'b1, 0);
        drain("t5");

        // Test 3: backpressure fills the FIFO, then a random sink drains it.
        ready_mode = 1;
        repeat (2) @(negedge clk);
        fork
            send_stream("ABCDEFG", 1'b1, 1'b1, 0);
        join_none
        repeat (12) @(negedge clk);
        #2;
        chk("t3_in_ready_full", 32'(in_ready), 32'd0);
        chk("t3_head", {out_valid, out_char, out_count, out_last},
            {1'b1, 8'h41, 4'd1, 1'b0});
        ready_mode = 2;
        wait fork;
        drain("t3");

        // Test 6: asynchronous reset mid-stream.
        ready_mode = 1;
        repeat (2) @(negedge clk);
        send_stream("AAB", 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        #2;
        chk("t6_pre_reset_head", {out_valid, out_char, out_count, out_last},
            {1'b1, 8'h41, 4'd2, 1'b0});
        mon_en = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("t6_async_out_valid", 32'(out_valid), 32'd0);
        chk("t6_async_out_data",  {out_char, out_count, out_last}, 32'd0);
        chk("t6_async_in_ready",  32'(in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        mon_en     = 1'b1;
        ready_mode = 0;
        send_stream("C", 1'b1, 1'b1, 0);
        drain("t6");

        // Randomised streams with long runs, gaps and random backpressure.
        ready_mode = 2;
        for (int t = 0; t < 25; t++) begin
            s = "";
            for (int seg = 0; seg < $urandom_range(1, 5); seg++) begin
                byte c = 8'h41 + 8'($urandom_range(0, 2));
                int  len = $urandom_range(1, 20);
                for (int j = 0; j < len; j++) s = $sformatf("%s%c", s, c);
            end
            $display("stream %0d: %s", t, s);
            send_stream(s, 1'b1, 1'b1, 2);
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
